// File: rtl/led_pkg.sv
// Shared definitions for the RGB LED pattern sequencer: colour codes,
// controller states and pattern-entry field layout helpers.
package led_pkg;

  // Colour codes are active-high: bit0 = red, bit1 = green, bit2 = blue.
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] LED_OFF   = 3'b000;
  localparam logic [COLOUR_W-1:0] LED_RED   = 3'b001;
  localparam logic [COLOUR_W-1:0] LED_GREEN = 3'b010;
  localparam logic [COLOUR_W-1:0] LED_BLUE  = 3'b100;
  localparam logic [COLOUR_W-1:0] LED_WHITE = 3'b111;

  // Controller states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A pattern entry is {colour, dur}; dur sits in the low bits.
  function automatic int entry_w(input int dur_w);
    return COLOUR_W + dur_w;
  endfunction

  function automatic int colour_lsb(input int dur_w);
    return dur_w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 and pulses tick on the
// terminal count. clr holds the counter at 0 so the first tick after
// release comes exactly TICK_DIV cycles later.
module tick_prescaler #(
  parameter int TICK_DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter with wrap on terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/rgb_led_sequencer.sv
// Programmable colour-pattern scheduler for an active-low RGB LED.
// A small table of {colour, dur} steps is walked on a prescaled tick.
// The control core (state, idx, dur_cnt) decides at each edge; busy, done
// and the LED pins are a registered view of the core taken one edge later,
// so every output is a flop and the LED always shows the step idx held.
//
// Write port: wr_en is a one-cycle strobe with no back-pressure; when
// wr_en is high at a clock edge, wr_data is stored at wr_addr on that edge,
// in any state. Reads of the active entry see the new value from the
// following cycle.
module rgb_led_sequencer
  import led_pkg::*;
#(
  parameter int TICK_DIV = 12000,
  parameter int DEPTH    = 8,
  parameter int DUR_W    = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [COLOUR_W+DUR_W-1:0] wr_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  input  logic [AW-1:0]             end_idx,
  output logic                      busy,
  output logic                      done,
  output logic [AW-1:0]             idx,
  output logic                      r,
  output logic                      g,
  output logic                      b
);

  localparam int ENTRY_W = entry_w(DUR_W);
  localparam int COL_LSB = colour_lsb(DUR_W);

  // Pattern table, no reset: software fills it before starting.
  logic [ENTRY_W-1:0] pat_mem [DEPTH];

  // Core state.
  state_t           state, state_nx;
  logic [AW-1:0]    idx_q, idx_nx;
  logic [DUR_W-1:0] dur_cnt, dur_nx;
  logic             loop_q, loop_nx;
  logic [AW-1:0]    end_q, end_nx;
  logic             fin_q, fin_nx;

  // Active entry decode (asynchronous read by idx).
  logic [ENTRY_W-1:0]  cur_entry;
  logic [COLOUR_W-1:0] cur_colour;
  logic [DUR_W-1:0]    cur_dur;
  logic [DUR_W-1:0]    eff_dur;
  logic                step_end;
  logic                tick;

  assign cur_entry  = pat_mem[idx_q];
  assign cur_colour = cur_entry[COL_LSB +: COLOUR_W];
  assign cur_dur    = cur_entry[DUR_W-1:0];
  assign eff_dur    = (cur_dur == '0) ? DUR_W'(1) : cur_dur;
  // >= rather than == so that shrinking the active step's dur below the
  // running count still ends the step on the next tick.
  assign step_end   = (dur_cnt >= (eff_dur - DUR_W'(1)));

  // Prescaler is held cleared outside RUN so each run starts on a fresh phase.
  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (state != RUN),
    .tick(tick)
  );

  // Table write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pat_mem[wr_addr] <= wr_data;
    end
  end

  // Core state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      dur_cnt <= '0;
      loop_q  <= 1'b0;
      end_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      idx_q   <= idx_nx;
      dur_cnt <= dur_nx;
      loop_q  <= loop_nx;
      end_q   <= end_nx;
      fin_q   <= fin_nx;
    end
  end

  // Next-state logic: start/stop handling and step sequencing on ticks.
  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    dur_nx   = dur_cnt;
    loop_nx  = loop_q;
    end_nx   = end_q;
    fin_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = RUN;
          loop_nx  = loop;
          end_nx   = end_idx;
          idx_nx   = '0;
          dur_nx   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (tick) begin
          if (!step_end) begin
            dur_nx = dur_cnt + DUR_W'(1);
          end else if (idx_q != end_q) begin
            idx_nx = idx_q + AW'(1);
            dur_nx = '0;
          end else if (loop_q) begin
            idx_nx = '0;
            dur_nx = '0;
          end else begin
            state_nx = IDLE;
            fin_nx   = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Registered outputs: one-edge view of the core, LEDs dark outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      {b, g, r} <= 3'b111;
    end else begin
      busy      <= (state == RUN);
      done      <= fin_q;
      {b, g, r} <= (state == RUN) ? ~cur_colour : 3'b111;
    end
  end

  assign idx = idx_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer with TICK_DIV=4. A cycle-level behavioural
// model tracks elapsed run time and ticks per step; its expected outputs go
// through exp_q and are compared against the DUT on every negedge. Directed
// tests additionally pin exact LED durations and done timing with literals.
module tb_rgb_led_sequencer;

  localparam int TD    = 4;
  localparam int DEPTH = 8;
  localparam int DUR_W = 8;
  localparam int AW    = 3;

  localparam logic [2:0] C_RED   = 3'b001;
  localparam logic [2:0] C_GREEN = 3'b010;
  localparam logic [2:0] C_BLUE  = 3'b100;
  localparam logic [2:0] C_WHITE = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DUR_W+2:0] wr_data;
  logic             start, stop, loop;
  logic [AW-1:0]    end_idx;
  logic             busy, done;
  logic [AW-1:0]    idx;
  logic             r, g, b;

  int total = 0;
  int bad   = 0;

  rgb_led_sequencer #(
    .TICK_DIV(TD),
    .DEPTH   (DEPTH),
    .DUR_W   (DUR_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start  (start),
    .stop   (stop),
    .loop   (loop),
    .end_idx(end_idx),
    .busy   (busy),
    .done   (done),
    .idx    (idx),
    .r      (r),
    .g      (g),
    .b      (b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_col [DEPTH];
  int m_dur [DEPTH];
  bit m_run = 1'b0;
  bit m_fin = 1'b0;
  bit m_loop = 1'b0;
  int m_end = 0;
  int m_idx = 0;
  int m_elapsed = 0;
  int m_ticks = 0;
  logic [7:0] exp_q[$];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_col[i] = 0;
      m_dur[i] = 0;
    end
  end

  always @(posedge clk) begin
    logic [7:0] e;
    bit nb, nd;
    logic [2:0] nrgb;
    int eff;
    if (rst) begin
      m_run = 1'b0;
      m_fin = 1'b0;
      m_idx = 0;
      e = {1'b0, 1'b0, 3'd0, 3'b111};
    end else begin
      nb   = m_run;
      nd   = m_fin;
      nrgb = m_run ? ~3'(m_col[m_idx]) : 3'b111;
      m_fin = 1'b0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1'b1;
          m_loop = loop;
          m_end = int'(end_idx);
          m_idx = 0;
          m_elapsed = 0;
          m_ticks = 0;
        end
      end else if (stop) begin
        m_run = 1'b0;
      end else begin
        if ((m_elapsed % TD) == TD - 1) begin
          m_ticks++;
          eff = (m_dur[m_idx] == 0) ? 1 : m_dur[m_idx];
          if (m_ticks >= eff) begin
            m_ticks = 0;
            if (m_idx != m_end) m_idx++;
            else if (m_loop) m_idx = 0;
            else begin
              m_run = 1'b0;
              m_fin = 1'b1;
            end
          end
        end
        m_elapsed++;
      end
      e = {nb, nd, 3'(m_idx), nrgb};
    end
    if (wr_en) begin
      m_col[wr_addr] = int'(wr_data[DUR_W +: 3]);
      m_dur[wr_addr] = int'(wr_data[DUR_W-1:0]);
    end
    exp_q.push_back(e);
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy", int'(busy), int'(e[7]));
      check("done", int'(done), int'(e[6]));
      check("idx", int'(idx), int'(e[5:3]));
      check("bgr", int'({b, g, r}), int'(e[2:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int addr, input logic [2:0] col, input int dur);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = {col, DUR_W'(dur)};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  int n_r, n_g, n_b, n_lit, n_white, n_done, first_lit, done_pos;

  // Samples DUT outputs for n cycles; optionally holds start, pulses stop,
  // or issues a pre-staged write at given cycle offsets.
  task automatic measure(input int n, input int start_hold, input int stop_at,
                         input int wr_at);
    n_r = 0; n_g = 0; n_b = 0; n_lit = 0; n_white = 0; n_done = 0;
    first_lit = -1; done_pos = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!r) n_r++;
      if (!g) n_g++;
      if (!b) n_b++;
      if ({b, g, r} != 3'b111) begin
        n_lit++;
        if (first_lit < 0) first_lit = i;
      end
      if ({b, g, r} == 3'b000) n_white++;
      if (done) begin
        n_done++;
        done_pos = i;
      end
      start = (i < start_hold);
      stop  = (i == stop_at);
      wr_en = (i == wr_at);
    end
    start = 1'b0;
    stop  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic go(input bit lp, input int last);
    loop    = lp;
    end_idx = AW'(last);
    start   = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; end_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_bgr", int'({b, g, r}), 7);
    rst = 1'b0;
    @(negedge clk);

    // One-shot three-step pattern.
    wr(0, C_RED, 2);
    wr(1, C_GREEN, 1);
    wr(2, C_BLUE, 3);
    go(1'b0, 2);
    measure(40, 0, -1, -1);
    check("a_red_cycles", n_r, 8);
    check("a_green_cycles", n_g, 4);
    check("a_blue_cycles", n_b, 12);
    check("a_done_count", n_done, 1);
    check("a_done_delay", done_pos - first_lit, 24);
    check("a_busy_after", int'(busy), 0);
    repeat (2) @(negedge clk);

    // Looping pattern, then abort.
    go(1'b1, 2);
    measure(48, 0, -1, -1);
    check("b_red_cycles", n_r, 16);
    check("b_done_count", n_done, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    check("b_stop_bgr", int'({b, g, r}), 7);
    check("b_stop_busy", int'(busy), 0);
    check("b_stop_done", int'(done), 0);
    repeat (3) @(negedge clk);

    // start held high through RUN has no effect.
    go(1'b0, 2);
    measure(40, 10, -1, -1);
    check("d_red_cycles", n_r, 8);
    check("d_green_cycles", n_g, 4);
    check("d_blue_cycles", n_b, 12);
    check("d_done_count", n_done, 1);
    check("d_done_delay", done_pos - first_lit, 24);
    repeat (2) @(negedge clk);

    // start and stop together in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ss_busy", int'(busy), 0);
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk);

    // dur=0 behaves as one tick.
    wr(0, C_RED, 0);
    go(1'b0, 0);
    measure(10, 0, -1, -1);
    check("c_red_cycles", n_r, 4);
    check("c_done_count", n_done, 1);
    check("c_done_delay", done_pos - first_lit, 4);
    repeat (2) @(negedge clk);

    // Overwrite the active entry's colour mid-step.
    wr(0, C_RED, 2);
    go(1'b0, 0);
    wr_addr = '0;
    wr_data = {C_WHITE, DUR_W'(2)};
    measure(14, 0, -1, 3);
    check("e_lit_cycles", n_lit, 8);
    check("e_white_cycles", n_white, 4);
    check("e_done_count", n_done, 1);
    check("e_done_delay", done_pos - first_lit, 8);
    repeat (2) @(negedge clk);

    // Reset mid-RUN.
    wr(0, C_RED, 2);
    go(1'b1, 2);
    measure(10, 0, -1, -1);
    rst = 1'b1;
    @(negedge clk);
    check("f_rst_busy", int'(busy), 0);
    check("f_rst_done", int'(done), 0);
    check("f_rst_idx", int'(idx), 0);
    check("f_rst_bgr", int'({b, g, r}), 7);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
